// File: rtl/zmips_pkg.sv
// zmips_pkg: constants and types shared by the zMIPS data-memory responder.
//   - MMIO base/offset addresses
//   - STAT register bit positions
//   - RAM region selector (address bits [31:28])
//   - decoded-target enum and an MMIO address-match helper
package zmips_pkg;

  localparam logic [31:0] MMIO_BASE = 32'hF000_0000;
  localparam logic [31:0] OFF_GPIO  = 32'h0000_0000;
  localparam logic [31:0] OFF_CNT   = 32'h0000_0004;
  localparam logic [31:0] OFF_CON   = 32'h0000_0008;
  localparam logic [31:0] OFF_STAT  = 32'h0000_000C;

  localparam logic [3:0] RAM_REGION = 4'h0;

  localparam int STAT_CNT_LSB = 0;
  localparam int STAT_CNT_W   = 5;
  localparam int STAT_FULL    = 8;
  localparam int STAT_EMPTY   = 9;
  localparam int STAT_OVF     = 16;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_GPIO,
    SEL_CNT,
    SEL_CON,
    SEL_STAT
  } sel_e;

  // Word-granular match against an MMIO register; byte-offset bits are ignored.
  function automatic logic mmio_hit(input logic [31:0] addr, input logic [31:0] off);
    logic [31:0] reg_addr;
    reg_addr = MMIO_BASE | off;
    return addr[31:2] == reg_addr[31:2];
  endfunction

endpackage

// File: rtl/zmips_sync_fifo.sv
// zmips_sync_fifo: small single-clock FIFO built from registers.
//   clk, rst      clock, asynchronous active-high reset (empties the FIFO)
//   push, din     write request and data
//   pop           read request (ignored when empty)
//   ovf_clr       clear the sticky overflow flag (an overflow in the same cycle wins)
//   dout          head entry, 0 when empty
//   full, empty, count, overflow   status, all from registered state
module zmips_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             ovf_clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;
  logic             ovf_set;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = empty ? '0 : mem[rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign ovf_set = push & full & ~pop_ok;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        mem[gi] <= '0;
      else if (push_ok && (wr_ptr == PW'(gi)))
        mem[gi] <= din;
    end
  end

  // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/zmips_dmem_resp.sv
// zmips_dmem_resp: responder side of the zMIPS data-memory interface.
// Acts on posedge so read data is stable before the core's negedge capture.
//   clk, rst            clock, asynchronous active-high reset
//   d_addr              byte address (bits [1:0] ignored)
//   d_data_o            write data from core
//   d_data_i            registered read data to core (holds when d_rd=0)
//   d_rd, d_wr          read / write request levels
//   gpio_out            GPIO output register
//   con_data, con_valid console FIFO head byte / not-empty
//   con_ready           console consumer pops the head at posedge
// Map: 0x0xxx_xxxx RAM (aliased), 0xF000_0000 GPIO, +4 CNT, +8 CON, +C STAT.
module zmips_dmem_resp
  import zmips_pkg::*;
#(
  parameter int RAM_AW     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_data_o,
  output logic [31:0] d_data_i,
  input  logic        d_rd,
  input  logic        d_wr,
  output logic [31:0] gpio_out,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  sel_e              sel;
  sel_e              sel_q;
  logic [31:0]       ram [2**RAM_AW];
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       ram_q;
  logic [31:0]       mmio_rd;
  logic [31:0]       mmio_q;
  logic [31:0]       cnt;
  logic [31:0]       stat_word;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FCW-1:0]    fifo_count;
  logic              fifo_ovf;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^d_addr[1:0];
  assign ram_idx = d_addr[RAM_AW+1:2];

  always_comb begin
    sel = SEL_NONE;
    if (d_addr[31:28] == RAM_REGION)    sel = SEL_RAM;
    else if (mmio_hit(d_addr, OFF_GPIO)) sel = SEL_GPIO;
    else if (mmio_hit(d_addr, OFF_CNT))  sel = SEL_CNT;
    else if (mmio_hit(d_addr, OFF_CON))  sel = SEL_CON;
    else if (mmio_hit(d_addr, OFF_STAT)) sel = SEL_STAT;
  end

  // RAM: plain posedge process so it maps onto block RAM. Write and read in
  // the same process give read-before-write naturally. The write is gated by
  // rst so a reset edge never commits a partial access.
  always_ff @(posedge clk) begin
    if (!rst && d_wr && sel == SEL_RAM)
      ram[ram_idx] <= d_data_o;
    if (d_rd && sel == SEL_RAM)
      ram_q <= ram[ram_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      gpio_out <= '0;
    else if (d_wr && sel == SEL_GPIO)
      gpio_out <= d_data_o;
  end

  // Free-running counter; a write loads 0 instead of incrementing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (d_wr && sel == SEL_CNT)
      cnt <= '0;
    else
      cnt <= cnt + 32'd1;
  end

  zmips_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_con_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (d_wr && sel == SEL_CON),
    .pop      (con_ready),
    .ovf_clr  (d_wr && sel == SEL_STAT && d_data_o[STAT_OVF]),
    .din      (d_data_o[7:0]),
    .dout     (con_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .overflow (fifo_ovf)
  );

  assign con_valid = ~fifo_empty;

  always_comb begin
    stat_word = '0;
    stat_word[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_count);
    stat_word[STAT_FULL]  = fifo_full;
    stat_word[STAT_EMPTY] = fifo_empty;
    stat_word[STAT_OVF]   = fifo_ovf;
  end

  always_comb begin
    mmio_rd = '0;
    case (sel)
      SEL_GPIO: mmio_rd = gpio_out;
      SEL_CNT:  mmio_rd = cnt;
      SEL_STAT: mmio_rd = stat_word;
      default:  mmio_rd = '0;
    endcase
  end

  // MMIO read data and the target select are captured alongside the RAM read;
  // resetting the select to SEL_NONE forces d_data_i to the reset mmio_q (0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mmio_q <= '0;
      sel_q  <= SEL_NONE;
    end else if (d_rd) begin
      mmio_q <= mmio_rd;
      sel_q  <= sel;
    end
  end

  assign d_data_i = (sel_q == SEL_RAM) ? ram_q : mmio_q;

endmodule

// File: tb/tb_zmips_dmem_resp.sv
module tb_zmips_dmem_resp;

  localparam logic [31:0] A_GPIO = 32'hF000_0000;
  localparam logic [31:0] A_CNT  = 32'hF000_0004;
  localparam logic [31:0] A_CON  = 32'hF000_0008;
  localparam logic [31:0] A_STAT = 32'hF000_000C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] d_addr = '0;
  logic [31:0] d_data_o = '0;
  logic [31:0] d_data_i;
  logic        d_rd = 1'b0;
  logic        d_wr = 1'b0;
  logic [31:0] gpio_out;
  logic [7:0]  con_data;
  logic        con_valid;
  logic        con_ready = 1'b0;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb[$];
  logic [7:0]  fq[$];
  logic [31:0] want;

  zmips_dmem_resp dut (
    .clk       (clk),
    .rst       (rst),
    .d_addr    (d_addr),
    .d_data_o  (d_data_o),
    .d_data_i  (d_data_i),
    .d_rd      (d_rd),
    .d_wr      (d_wr),
    .gpio_out  (gpio_out),
    .con_data  (con_data),
    .con_valid (con_valid),
    .con_ready (con_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] stat(input int cnt, input bit full, input bit empty, input bit ovf);
    stat = 32'(cnt) | (full ? 32'h100 : 32'h0) | (empty ? 32'h200 : 32'h0) | (ovf ? 32'h1_0000 : 32'h0);
  endfunction

  // One bus cycle: called at a negedge, drives the request, returns at the next negedge.
  task automatic bus(input logic [31:0] addr, input logic [31:0] wdata,
                     input logic rd, input logic wr, input logic [31:0] exp);
    d_addr = addr; d_data_o = wdata; d_rd = rd; d_wr = wr;
    if (rd) sb.push_back(exp);
    @(negedge clk);
    d_rd = 1'b0; d_wr = 1'b0;
    $display("[TB] bus addr=%h wdata=%h rd=%0b wr=%0b d_data_i=%h", addr, wdata, rd, wr, d_data_i);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++; if (d_data_i !== 32'h0) begin n_fail++; $display("FAIL rst_d_data_i got %h want 0", d_data_i); end
    n_tests++; if (gpio_out !== 32'h0) begin n_fail++; $display("FAIL rst_gpio got %h want 0", gpio_out); end
    n_tests++; if (con_valid !== 1'b0 || con_data !== 8'h0) begin n_fail++; $display("FAIL rst_con got v=%b d=%h want v=0 d=0", con_valid, con_data); end
    rst = 1'b0;
    bus(A_GPIO, 32'h0000_00AA, 0, 1, 0);
    bus(A_CON,  32'h0000_0099, 0, 1, 0);
    bus(A_GPIO, 32'h0, 1, 0, 32'h0000_00AA);
    want = sb.pop_front();
    n_tests++; if (d_data_i !== want) begin n_fail++; $display("FAIL pre_rst_gpio_rd got %h want %h", d_data_i, want); end
    n_tests++; if (con_valid !== 1'b1 || con_data !== 8'h99) begin n_fail++; $display("FAIL pre_rst_con got v=%b d=%h want v=1 d=99", con_valid, con_data); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (d_data_i !== 32'h0 || gpio_out !== 32'h0) begin n_fail++; $display("FAIL midrst_regs got d=%h g=%h want 0 0", d_data_i, gpio_out); end
    n_tests++; if (con_valid !== 1'b0 || con_data !== 8'h0) begin n_fail++; $display("FAIL midrst_con got v=%b d=%h want v=0 d=0", con_valid, con_data); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_counter();
    repeat (4) bus(32'h0, 32'h0, 0, 0, 0);
    bus(A_CNT, 32'h0, 1, 0, 32'd4);
    want = sb.pop_front();
    n_tests++; if (d_data_i !== want) begin n_fail++; $display("FAIL cnt_after_rst got %h want %h", d_data_i, want); end
    bus(A_CNT, 32'h1234, 0, 1, 0);
    bus(A_CNT, 32'h0, 1, 0, 32'd0);
    want = sb.pop_front();
    n_tests++; if (d_data_i !== want) begin n_fail++; $display("FAIL cnt_clear got %h want %h", d_data_i, want); end
    bus(A_CNT, 32'h0, 1, 0, 32'd1);
    want = sb.pop_front();
    n_tests++; if (d_data_i !== want) begin n_fail++; $display("FAIL cnt_incr got %h want %h", d_data_i, want); end
  endtask

  task automatic test_ram();
    bus(32'h0000_0010, 32'hCAFE_BABE, 0, 1, 0);
    bus(32'h0000_0014, 32'h0BAD_F00D, 0, 1, 0);
    bus(32'h0000_0010, 32'h0, 1, 0, 32'hCAFE_BABE);
    want = sb.pop_front();
    n_tests++; if (d_data_i !== want) begin n_fail++; $display("FAIL ram_rd got %h want %h", d_data_i, want); end
    bus(32'h0000_1010, 32'h0, 1, 0, 32'hCAFE_BABE);
    want = sb.pop_front();
    n_tests++; if (d_data_i !== want) begin n_fail++; $display("FAIL ram_alias got %h want %h", d_data_i, want); end
    bus(32'h0000_0017, 32'h0, 1, 0, 32'h0BAD_F00D);
    want = sb.pop_front();
    n_tests++; if (d_data_i !== want) begin n_fail++; $display("FAIL ram_lsb_ignored got %h want %h", d_data_i, want); end
    bus(32'h0000_0010, 32'h0, 0, 0, 0);
    n_tests++; if (d_data_i !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL ram_hold got %h want 0badf00d", d_data_i); end
  endtask

  task automatic test_fifo_fill();
    con_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus(A_CON, 32'h41 + 32'(i), 0, 1, 0);
      fq.push_back(8'h41 + 8'(i));
    end
    bus(A_STAT, 32'h0, 1, 0, stat(4, 1, 0, 0));
    want = sb.pop_front();
    n_tests++; if (d_data_i !== want) begin n_fail++; $display("FAIL stat_full got %h want %h", d_data_i, want); end
    bus(A_CON, 32'h45, 0, 1, 0);
    bus(A_STAT, 32'h0, 1, 0, stat(4, 1, 0, 1));
    want = sb.pop_front();
    n_tests++; if (d_data_i !== want) begin n_fail++; $display("FAIL stat_ovf got %h want %h", d_data_i, want); end
    con_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      want = {24'h0, fq.pop_front()};
      n_tests++; if (con_valid !== 1'b1 || con_data !== want[7:0]) begin n_fail++; $display("FAIL drain1_%0d got v=%b d=%h want v=1 d=%h", i, con_valid, con_data, want[7:0]); end
      @(negedge clk);
    end
    con_ready = 1'b0;
    n_tests++; if (con_valid !== 1'b0) begin n_fail++; $display("FAIL drain1_empty got v=%b want 0", con_valid); end
    bus(A_STAT, 32'h0, 1, 0, stat(0, 0, 1, 1));
    want = sb.pop_front();
    n_tests++; if (d_data_i !== want) begin n_fail++; $display("FAIL stat_empty got %h want %h", d_data_i, want); end
    bus(A_STAT, 32'h0001_0000, 0, 1, 0);
    bus(A_STAT, 32'h0, 1, 0, stat(0, 0, 1, 0));
    want = sb.pop_front();
    n_tests++; if (d_data_i !== want) begin n_fail++; $display("FAIL stat_ovf_clr got %h want %h", d_data_i, want); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      bus(A_CON, 32'h51 + 32'(i), 0, 1, 0);
      fq.push_back(8'h51 + 8'(i));
    end
    n_tests++; if (con_data !== 8'h51) begin n_fail++; $display("FAIL b2b_head got %h want 51", con_data); end
    con_ready = 1'b1;
    bus(A_CON, 32'h55, 0, 1, 0);
    con_ready = 1'b0;
    void'(fq.pop_front());
    fq.push_back(8'h55);
    bus(A_STAT, 32'h0, 1, 0, stat(4, 1, 0, 0));
    want = sb.pop_front();
    n_tests++; if (d_data_i !== want) begin n_fail++; $display("FAIL b2b_stat got %h want %h", d_data_i, want); end
    con_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      want = {24'h0, fq.pop_front()};
      n_tests++; if (con_valid !== 1'b1 || con_data !== want[7:0]) begin n_fail++; $display("FAIL drain2_%0d got v=%b d=%h want v=1 d=%h", i, con_valid, con_data, want[7:0]); end
      @(negedge clk);
    end
    con_ready = 1'b0;
    n_tests++; if (con_valid !== 1'b0) begin n_fail++; $display("FAIL drain2_empty got v=%b want 0", con_valid); end
  endtask

  task automatic test_rd_wr_same();
    bus(A_GPIO, 32'h1234, 0, 1, 0);
    bus(A_GPIO, 32'h5678, 1, 1, 32'h1234);
    want = sb.pop_front();
    n_tests++; if (d_data_i !== want) begin n_fail++; $display("FAIL gpio_rbw got %h want %h", d_data_i, want); end
    n_tests++; if (gpio_out !== 32'h5678) begin n_fail++; $display("FAIL gpio_out got %h want 00005678", gpio_out); end
    bus(32'h0000_0020, 32'h1111_1111, 0, 1, 0);
    bus(32'h0000_0020, 32'h2222_2222, 1, 1, 32'h1111_1111);
    want = sb.pop_front();
    n_tests++; if (d_data_i !== want) begin n_fail++; $display("FAIL ram_rbw got %h want %h", d_data_i, want); end
    bus(32'h0000_0020, 32'h0, 1, 0, 32'h2222_2222);
    want = sb.pop_front();
    n_tests++; if (d_data_i !== want) begin n_fail++; $display("FAIL ram_after_rbw got %h want %h", d_data_i, want); end
    bus(A_CNT, 32'h0, 0, 1, 0);
    bus(32'h0, 32'h0, 0, 0, 0);
    bus(32'h0, 32'h0, 0, 0, 0);
    bus(A_CNT, 32'h0, 1, 1, 32'd2);
    want = sb.pop_front();
    n_tests++; if (d_data_i !== want) begin n_fail++; $display("FAIL cnt_rbw got %h want %h", d_data_i, want); end
    bus(A_CNT, 32'h0, 1, 0, 32'd0);
    want = sb.pop_front();
    n_tests++; if (d_data_i !== want) begin n_fail++; $display("FAIL cnt_after_rbw got %h want %h", d_data_i, want); end
  endtask

  task automatic test_unmapped();
    bus(A_GPIO, 32'h0, 1, 0, 32'h5678);
    want = sb.pop_front();
    n_tests++; if (d_data_i !== want) begin n_fail++; $display("FAIL gpio_rd got %h want %h", d_data_i, want); end
    bus(32'h8000_0000, 32'hDEAD_BEEF, 0, 1, 0);
    bus(32'h8000_0000, 32'h0, 1, 0, 32'h0);
    want = sb.pop_front();
    n_tests++; if (d_data_i !== want) begin n_fail++; $display("FAIL unmapped_rd got %h want %h", d_data_i, want); end
    n_tests++; if (gpio_out !== 32'h5678) begin n_fail++; $display("FAIL unmapped_wr got gpio %h want 00005678", gpio_out); end
    bus(A_GPIO, 32'h0, 1, 0, 32'h5678);
    void'(sb.pop_front());
    bus(A_CON, 32'h0, 1, 0, 32'h0);
    want = sb.pop_front();
    n_tests++; if (d_data_i !== want) begin n_fail++; $display("FAIL con_rd got %h want %h", d_data_i, want); end
    bus(A_GPIO, 32'h0, 1, 0, 32'h5678);
    void'(sb.pop_front());
    bus(32'hF000_0010, 32'h0, 1, 0, 32'h0);
    want = sb.pop_front();
    n_tests++; if (d_data_i !== want) begin n_fail++; $display("FAIL mmio_gap_rd got %h want %h", d_data_i, want); end
  endtask

  initial begin
    test_reset();
    test_counter();
    test_ram();
    test_fifo_fill();
    test_back_to_back();
    test_rd_wr_same();
    test_unmapped();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/zmips_dmem_resp.md
Name: zmips_dmem_resp

Overview:
- Responder (slave) end of the zMIPS data-memory interface; the pipeline's MEM stage is the initiator.
- Decodes d_addr/d_rd/d_wr from the core and serves a word-addressed data RAM plus a small MMIO block.
- MMIO block: GPIO output register, free-running cycle counter, and console byte FIFO with ready/valid drain.
- Works on the opposite clock edge to the core: responder acts on posedge, so read data is valid before the core's negedge capture.

Parameters:
- RAM_AW, 10, log2 of RAM depth in 32-bit words (default 1024 words = 4 KiB).
- FIFO_DEPTH, 4, console FIFO depth in bytes; power of two, 2..16.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- d_addr  in  32  byte address from core; bits [1:0] ignored (word access only).
- d_data_o  in  32  write data from core.
- d_data_i  out  32  read data to core.
- d_rd  in  1  read request, level, one access per clk.
- d_wr  in  1  write request, level, one access per clk.
- gpio_out  out  32  GPIO output register.
- con_data  out  8  console FIFO head byte.
- con_valid  out  1  FIFO not empty.
- con_ready  in  1  consumer accepts con_data this posedge.

Behaviour:
- Reset (async, rst=1): d_data_i=0, gpio_out=0, counter=0, FIFO empty (con_valid=0, con_data=0), overflow=0. RAM contents are not reset.
- Address decode:
  - d_addr[31:28]==4'h0 → RAM, word index d_addr[RAM_AW+1:2]; higher bits inside the region alias.
  - 0xF000_0000 GPIO (RW).
  - 0xF000_0004 CNT (RO; any write clears it).
  - 0xF000_0008 CON (W: push d_data_o[7:0]; R returns 0).
  - 0xF000_000C STAT (R: [4:0] count, [8] full, [9] empty, [16] overflow; W with d_data_o[16]=1 clears overflow).
  - Any other address: reads return 0, writes ignored.
- Read timing: at posedge with d_rd=1, d_data_i <= selected word (registered, 1 posedge latency). Core samples it at the next negedge.
  - With d_rd=0, d_data_i holds its last value.
- Write timing: at posedge with d_wr=1, the target is updated. The value is visible to a read at the following posedge.
- d_rd and d_wr both high: write is performed; d_data_i returns the pre-write contents (read-before-write), including for the RAM and CNT.
- Counter: increments every posedge and wraps 0xFFFF_FFFF → 0.
  - A write to CNT loads 0 (no increment that cycle).
  - A CNT read returns the value before that edge's increment.
- FIFO:
  - Push on a CON write; pop at posedge when con_valid & con_ready.
  - con_data/con_valid come from registered state, so they are stable through a cycle.
  - Push when full without a pop: byte dropped, overflow set (sticky).
  - Push and pop in the same cycle when full: both happen, count unchanged, no overflow.
  - Push and pop in the same cycle when empty: push only.
  - Pointers wrap modulo FIFO_DEPTH.
  - If STAT overflow-clear and an overflowing push coincide: set wins.
- Reset mid-operation: everything returns to reset values immediately, including in-flight FIFO contents. No partial write is committed.

Decomposition:
- Shared package zmips_pkg holds:
  - MMIO base/offset constants (MMIO_BASE=32'hF000_0000, OFF_GPIO/CNT/CON/STAT).
  - STAT bit positions.
  - RAM region select constant.
- One sub-module: zmips_sync_fifo, parameterised width/depth, with push/pop/full/empty/count/overflow outputs.
- RAM is an inferred array inside zmips_dmem_resp.

Test Plan:
- RAM: write 0xCAFEBABE to 0x0000_0010, then read 0x0000_0010 → d_data_i=0xCAFEBABE one posedge later. Read 0x0000_1010 (alias, RAM_AW=10) → 0xCAFEBABE.
- Reset and counter:
  - Assert rst mid-cycle → d_data_i, gpio_out, counter immediately 0 and con_valid=0.
  - After release, read CNT at the 5th posedge → 4.
  - Write CNT, then read → 0.
- FIFO fill with con_ready=0:
  - Push 0x41..0x44 → STAT reads count=4, full=1, overflow=0.
  - Push 0x45 → overflow=1; 0x45 is lost.
  - Raise con_ready → con_data sequence 0x41,0x42,0x43,0x44, then con_valid=0, empty=1.
- Full FIFO push and pop in the same cycle with con_ready=1: count stays 4, overflow stays 0, new byte appears last.
- Simultaneous d_rd+d_wr to GPIO (old 0x1234, new 0x5678) → d_data_i=0x1234, gpio_out=0x5678.
- Unmapped and MMIO edge cases: read 0x8000_0000 → 0. Read CON → 0. Write STAT with bit16=1 → overflow cleared.
